// File: rtl/eth_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD/FCS, filters on destination MAC and flags
// length errors. Define ETH_RX_CRC_CHECK_EN to also flag frames whose CRC-32 check fails.
module eth_rx_frame_parser #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter int          PRE_MIN   = 1,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gmii_rx_dv,
  input  logic [7:0] gmii_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       rx_busy
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam int          DL_DEPTH  = 5;
  localparam logic [2:0]  PRE_MIN_C = 3'(PRE_MIN);
  localparam logic [10:0] MIN_POS   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_POS   = 11'(MAX_LEN);
  localparam logic [10:0] DA_POS    = 11'(DL_DEPTH);

  state_t      state, state_nxt;
  logic [2:0]  pre_cnt;
  logic [10:0] pos;
  logic [7:0]  dl [DL_DEPTH];
  logic        wait_idle;

  logic        is_pre, is_sfd, sfd_hit, da_pos, da_ok, over_pos, len_err, crc_err;
  logic        emit, emit_sop, emit_eop, emit_err;
  logic [47:0] da;

  assign is_pre   = (gmii_rxd == 8'h55);
  assign is_sfd   = (gmii_rxd == 8'hD5);
  assign sfd_hit  = (state == PREAMBLE) && gmii_rx_dv && is_sfd && (pre_cnt >= PRE_MIN_C);
  assign da_pos   = (pos == DA_POS);
  assign over_pos = (pos == MAX_POS);
  assign len_err  = (pos < MIN_POS);
  // DA bytes 0..4 sit in the delay line while byte 5 is on the input.
  assign da       = {dl[4], dl[3], dl[2], dl[1], dl[0], gmii_rxd};
  assign da_ok    = (da == BOARD_MAC) || (da == 48'hFFFF_FFFF_FFFF);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) state_nxt = (is_pre && !wait_idle) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!gmii_rx_dv)  state_nxt = IDLE;
        else if (sfd_hit) state_nxt = DATA;
        else if (!is_pre) state_nxt = DROP;
      end
      DATA: begin
        if (!gmii_rx_dv)             state_nxt = IDLE;
        else if (da_pos && !da_ok)   state_nxt = DROP;
        else if (over_pos)           state_nxt = DROP;
      end
      DROP: begin
        if (!gmii_rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte k leaves the delay line when position k+5 is sampled (data or the first dv=0).
  always_comb begin
    emit     = 1'b0;
    emit_sop = 1'b0;
    emit_eop = 1'b0;
    emit_err = 1'b0;
    rx_busy  = (state == DATA);
    if (state == DATA) begin
      if (gmii_rx_dv) begin
        if (da_pos) begin
          emit     = da_ok;
          emit_sop = da_ok;
        end else if (pos > DA_POS) begin
          emit     = 1'b1;
          emit_eop = over_pos;
          emit_err = over_pos;
        end
      end else if (pos > DA_POS) begin
        emit     = 1'b1;
        emit_eop = 1'b1;
        emit_err = len_err || crc_err;
      end
    end
  end

  // NOTE: the delay line is cleared on reset so a stale DA can never pass the filter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt   <= 3'd0;
      pos       <= 11'd0;
      wait_idle <= 1'b1;
      for (int i = 0; i < DL_DEPTH; i++) dl[i] <= 8'h00;
    end else begin
      if (!gmii_rx_dv) wait_idle <= 1'b0;

      if (state == IDLE)
        pre_cnt <= 3'd1;
      else if (state == PREAMBLE && gmii_rx_dv && is_pre && pre_cnt != 3'd7)
        pre_cnt <= pre_cnt + 3'd1;

      if (sfd_hit) begin
        pos <= 11'd0;
        for (int i = 0; i < DL_DEPTH; i++) dl[i] <= 8'h00;
      end else if (state == DATA && gmii_rx_dv) begin
        if (pos != 11'h7FF) pos <= pos + 11'd1;
        dl[0] <= gmii_rxd;
        for (int i = 1; i < DL_DEPTH; i++) dl[i] <= dl[i-1];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_sop   <= 1'b0;
      rx_eop   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_data  <= emit ? dl[DL_DEPTH-1] : 8'h00;
      rx_valid <= emit;
      rx_sop   <= emit_sop;
      rx_eop   <= emit_eop;
      rx_err   <= emit_err;
    end
  end

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n)                            crc <= 32'hFFFF_FFFF;
    else if (sfd_hit)                      crc <= 32'hFFFF_FFFF;
    else if (state == DATA && gmii_rx_dv)  crc <= crc32_step(crc, gmii_rxd);
  end

  // Running the register over data plus FCS leaves the fixed residue on a good frame.
  assign crc_err = (crc != 32'hDEBB_20E3);
`else
  assign crc_err = 1'b0;
`endif

endmodule
